// File: rtl/rv_pkg.sv
// rv_pkg: shared definitions for the fetch sequencer.
//   - RV32I control-flow opcodes (instr[6:0])
//   - default halt opcode
//   - fetch sequencer state enumeration
package rv_pkg;

    localparam logic [6:0] OP_JAL          = 7'b1101111;
    localparam logic [6:0] OP_JALR         = 7'b1100111;
    localparam logic [6:0] OP_BRANCH       = 7'b1100011;
    localparam logic [6:0] HALT_OPCODE_DEF = 7'h7F;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_TRAP = 2'd2
    } state_e;

endpackage

// File: rtl/rv_imm_gen.sv
// rv_imm_gen: RV32I immediate extraction for the fetch sequencer.
// Ports:
//   instr  in  instruction bits [31:7] (opcode bits are not needed here)
//   imm_i  out sign-extended I-immediate (JALR offset)
//   imm_j  out sign-extended J-immediate (JAL offset)
//   imm_b  out sign-extended B-immediate (branch offset)
module rv_imm_gen #(
    parameter int XLEN = 32
) (
    input  logic [31:7]     instr,
    output logic [XLEN-1:0] imm_i,
    output logic [XLEN-1:0] imm_j,
    output logic [XLEN-1:0] imm_b
);

    assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_j = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20],
                    instr[30:21], 1'b0};
    assign imm_b = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25],
                    instr[11:8], 1'b0};

endmodule

// File: rtl/rv_fetch_seq.sv
// rv_fetch_seq: single-issue PC sequencer with RUN/HALT/TRAP control.
// Ports:
//   CLOCK_50      in  clock, all state on rising edge
//   reset         in  synchronous active-high reset
//   instr         in  instruction at the current PC (zero-latency fetch)
//   rd1           in  rs1 value, JALR base
//   branch_taken  in  compare result for BRANCH
//   stall         in  hold the current instruction this cycle
//   PC / PC4      out current PC and PC+4 link value
//   PC_next       out PC register value for the next cycle
//   run / trap    out state RUN / state TRAP
//   jump          out control-flow redirect this cycle
//   instret       out retired-instruction count (wraps at 2^32)
// PC_W is assumed smaller than XLEN.
module rv_fetch_seq
    import rv_pkg::*;
#(
    parameter int              PC_W        = 11,
    parameter int              XLEN        = 32,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter logic [6:0]      HALT_OPCODE = HALT_OPCODE_DEF
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rd1,
    input  logic            branch_taken,
    input  logic            stall,
    output logic [PC_W-1:0] PC,
    output logic [PC_W-1:0] PC4,
    output logic [PC_W-1:0] PC_next,
    output logic            run,
    output logic            jump,
    output logic            trap,
    output logic [31:0]     instret
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     instret_q, instret_d;

    logic [XLEN-1:0] imm_i, imm_j, imm_b;
    logic [XLEN-1:0] pc_x, tgt_x;
    logic [PC_W-1:0] tgt;
    logic [6:0]      opcode;
    logic            is_jal, is_jalr, is_br, is_halt, redirect, misaligned;

    rv_imm_gen #(.XLEN(XLEN)) u_imm (
        .instr (instr[31:7]),
        .imm_i (imm_i),
        .imm_j (imm_j),
        .imm_b (imm_b)
    );

    assign opcode  = instr[6:0];
    assign is_jal  = (opcode == OP_JAL);
    assign is_jalr = (opcode == OP_JALR);
    assign is_br   = (opcode == OP_BRANCH);
    assign is_halt = (opcode == HALT_OPCODE);
    assign pc_x    = XLEN'(pc_q);

    // Target is formed at full XLEN width and then truncated, so the PC wraps
    // modulo 2^PC_W regardless of offset sign.
    always_comb begin
        tgt_x    = pc_x + XLEN'(4);
        redirect = 1'b0;
        if (is_jal) begin
            tgt_x    = pc_x + imm_j;
            redirect = 1'b1;
        end else if (is_jalr) begin
            tgt_x    = (rd1 + imm_i) & ~XLEN'(1);
            redirect = 1'b1;
        end else if (is_br && branch_taken) begin
            tgt_x    = pc_x + imm_b;
            redirect = 1'b1;
        end
    end

    assign tgt        = PC_W'(tgt_x);
    // Sequential targets are always word aligned, so only redirects can fault.
    assign misaligned = redirect && tgt[1];

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instret_d = instret_q;
        jump      = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (!stall) begin
                    jump = redirect;
                    // Halt is checked first so it wins over a misaligned target.
                    if (is_halt) begin
                        state_d = ST_HALT;
                    end else if (misaligned) begin
                        state_d = ST_TRAP;
                    end else begin
                        pc_d      = tgt;
                        instret_d = instret_q + 32'd1;
                    end
                end
            end
            default: ;  // HALT/TRAP: frozen until reset
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= ST_RUN;
            pc_q      <= RESET_PC;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instret_q <= instret_d;
        end
    end

    assign PC      = pc_q;
    assign PC4     = PC_W'(pc_x + XLEN'(4));
    assign PC_next = pc_d;
    assign run     = (state_q == ST_RUN);
    assign trap    = (state_q == ST_TRAP);
    assign instret = instret_q;

endmodule

// File: tb/tb_rv_fetch_seq.sv
// tb_rv_fetch_seq: directed scenarios plus randomized traffic checked against
// an arithmetic reference model of the fetch sequencer.
module tb_rv_fetch_seq;

    localparam int MASK = 32'h7FF;  // PC_W = 11

    localparam logic [31:0] ADDI = 32'h00500293;
    localparam logic [31:0] JAL  = 32'h00c000ef;
    localparam logic [31:0] JALR = 32'h00008067;
    localparam logic [31:0] HALT = 32'h0000007f;

    logic        CLOCK_50 = 1'b0;
    logic        reset, branch_taken, stall;
    logic [31:0] instr, rd1;
    logic [10:0] PC, PC4, PC_next;
    logic        run, jump, trap;
    logic [31:0] instret;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state: mode 0 = running, 1 = halted, 2 = trapped
    int          m_pc, m_mode;
    logic [31:0] m_cnt;
    int          e_next, e_mode;
    logic [31:0] e_cnt;
    logic        e_jump, e_rst;

    rv_fetch_seq #(.PC_W(11), .XLEN(32), .RESET_PC(11'h000), .HALT_OPCODE(7'h7F)) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .instr        (instr),
        .rd1          (rd1),
        .branch_taken (branch_taken),
        .stall        (stall),
        .PC           (PC),
        .PC4          (PC4),
        .PC_next      (PC_next),
        .run          (run),
        .jump         (jump),
        .trap         (trap),
        .instret      (instret)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Apply inputs mid-cycle, predict this cycle from the model, compare.
    task automatic drive(input logic [31:0] i, input logic [31:0] r, input logic bt,
                         input logic st, input logic rs);
        int imm_i, imm_b, imm_j, tgt;
        logic redir;
        @(negedge CLOCK_50);
        instr = i; rd1 = r; branch_taken = bt; stall = st; reset = rs;
        #2;
        imm_i = $signed(i) >>> 20;
        imm_b = (int'(i[7]) << 11) | (int'(i[30:25]) << 5) | (int'(i[11:8]) << 1);
        if (i[31]) imm_b -= 4096;
        imm_j = (int'(i[19:12]) << 12) | (int'(i[20]) << 11) | (int'(i[30:21]) << 1);
        if (i[31]) imm_j -= (1 << 20);

        redir = 1'b1;
        if (i[6:0] == 7'b1101111)                 tgt = (m_pc + imm_j) & MASK;
        else if (i[6:0] == 7'b1100111)            tgt = ((int'(r) + imm_i) & ~1) & MASK;
        else if (i[6:0] == 7'b1100011 && bt)      tgt = (m_pc + imm_b) & MASK;
        else begin tgt = (m_pc + 4) & MASK; redir = 1'b0; end

        e_next = m_pc; e_mode = m_mode; e_cnt = m_cnt; e_jump = 1'b0; e_rst = rs;
        if (m_mode == 0 && !st) begin
            e_jump = redir;
            if (i[6:0] == 7'h7F)                 e_mode = 1;
            else if (redir && ((tgt >> 1) & 1))  e_mode = 2;
            else begin e_next = tgt; e_cnt = m_cnt + 1; end
        end

        chk("pc",      32'(PC),      32'(m_pc));
        chk("pc4",     32'(PC4),     32'((m_pc + 4) & MASK));
        chk("run",     32'(run),     32'(m_mode == 0));
        chk("trap",    32'(trap),    32'(m_mode == 2));
        chk("instret", instret,      m_cnt);
        if (!rs) begin
            chk("pc_next", 32'(PC_next), 32'(e_next));
            chk("jump",    32'(jump),    32'(e_jump));
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        if (e_rst) begin
            m_pc = 0; m_mode = 0; m_cnt = 0;
        end else begin
            m_pc = e_next; m_mode = e_mode; m_cnt = e_cnt;
        end
    endtask

    initial begin
        logic [31:0] ri, rr;
        int k;
        instr = ADDI; rd1 = 0; branch_taken = 0; stall = 0; reset = 1;
        m_pc = 0; m_mode = 0; m_cnt = 0;

        // bring-up reset: model is not yet valid, so drive without predicting
        @(negedge CLOCK_50); @(negedge CLOCK_50);
        @(posedge CLOCK_50);
        #1 reset = 0;

        // reset state and two sequential instructions
        drive(ADDI, 0, 0, 0, 0);
        chk("rst_pc", 32'(PC), 32'h000); chk("rst_instret", instret, 0); chk("rst_run", 32'(run), 1);
        tick();
        drive(ADDI, 0, 0, 0, 0); chk("addi_pc1", 32'(PC), 32'h004); tick();

        // jal +12 at PC 0x008
        drive(JAL, 0, 0, 0, 0);
        chk("addi_pc2", 32'(PC), 32'h008); chk("addi_instret", instret, 2);
        chk("jal_jump", 32'(jump), 1); chk("jal_pc4", 32'(PC4), 32'h00c);
        chk("jal_next", 32'(PC_next), 32'h014);
        tick();

        // jalr to rd1=0x00c
        drive(JALR, 32'h00c, 0, 0, 0);
        chk("jal_pc", 32'(PC), 32'h014); chk("jalr_next", 32'(PC_next), 32'h00c);
        chk("jalr_jump", 32'(jump), 1);
        tick();
        drive(ADDI, 0, 0, 0, 0); tick();

        // stall three cycles at 0x010 with a jal presented
        for (int s = 0; s < 3; s++) begin
            drive(JAL, 0, 0, 1, 0);
            chk("stall_pc", 32'(PC), 32'h010); chk("stall_instret", instret, 5);
            chk("stall_jump", 32'(jump), 0); chk("stall_next", 32'(PC_next), 32'h010);
            tick();
        end
        drive(ADDI, 0, 0, 0, 0); tick();

        // misaligned jalr target 0x006 traps, PC held at 0x014
        drive(JALR, 32'h006, 0, 0, 0); tick();
        for (int s = 0; s < 3; s++) begin
            drive(JAL, 32'h00c, 1, s[0], 0);
            chk("trap_trap", 32'(trap), 1); chk("trap_run", 32'(run), 0);
            chk("trap_pc", 32'(PC), 32'h014); chk("trap_instret", instret, 6);
            tick();
        end
        drive(ADDI, 0, 0, 0, 1); tick();

        // halt at 0x000, frozen 5 cycles, then reset
        drive(HALT, 0, 0, 0, 0); tick();
        for (int s = 0; s < 5; s++) begin
            drive($urandom, $urandom, 1'($urandom), 1'($urandom), 0);
            chk("halt_run", 32'(run), 0); chk("halt_pc", 32'(PC), 32'h000);
            chk("halt_trap", 32'(trap), 0);
            tick();
        end
        drive(HALT, 0, 0, 1, 1); tick();
        drive(ADDI, 0, 0, 0, 0);
        chk("rerst_pc", 32'(PC), 32'h000); chk("rerst_run", 32'(run), 1);
        tick();

        // wrap: jump to 0x7fc, then a sequential instruction wraps to 0x000
        drive(JALR, 32'h7fc, 0, 0, 0); tick();
        drive(ADDI, 0, 0, 0, 0);
        chk("wrap_pc", 32'(PC), 32'h7fc); chk("wrap_next", 32'(PC_next), 32'h000);
        tick();
        drive(ADDI, 0, 0, 0, 0); chk("wrap_pc0", 32'(PC), 32'h000); tick();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            ri = $urandom;
            k  = $urandom_range(0, 9);
            case (k)
                0, 1:    ri[6:0] = 7'b1101111;
                2, 3:    ri[6:0] = 7'b1100111;
                4, 5:    ri[6:0] = 7'b1100011;
                6:       ri[6:0] = ($urandom_range(0, 3) == 0) ? 7'h7F : 7'h13;
                default: ri[6:0] = 7'h13;
            endcase
            rr = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 2047));
            drive(ri, rr, 1'($urandom), ($urandom_range(0, 3) == 0),
                  (m_mode != 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
